// File: rtl/cpu_fetch_stage.sv
// cpu_fetch_stage: instruction-fetch front end.
// Owns the PC and issues one word-addressed read per cycle to a synchronous
// instruction memory with 1-cycle read latency. Returned words are queued with
// their PCs in a small FIFO and handed to decode over a valid/ready handshake.
// A redirect from execute reloads the PC and throws away all fetched work.
module cpu_fetch_stage #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0,
    parameter int DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0]  pc;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_pc;

    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    logic               pop;
    logic               issue;
    logic [CNT_W:0]     credit_used;
    logic [PTR_W-1:0]   rd_ptr_inc;
    logic [PTR_W-1:0]   wr_ptr_inc;

    // Handshake, issue credit check and head presentation; outputs read zero when the FIFO is empty.
    always_comb begin
        out_valid   = (count != '0);
        pop         = out_valid && out_ready;
        credit_used = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
        issue       = reset && !redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));
        imem_rd_en  = issue;
        imem_addr   = pc;
        out_instr   = '0;
        out_pc      = '0;
        if (out_valid) begin
            out_instr = fifo_instr[rd_ptr];
            out_pc    = fifo_pc[rd_ptr];
        end
        rd_ptr_inc  = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        wr_ptr_inc  = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end

    // PC and the single outstanding request; a redirect cancels the returning word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= ADDR_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + 1'b1;
                inflight_pc <= pc;
            end
        end
    end

    // FIFO bookkeeping: returning word pushes, accepted head pops, redirect empties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (inflight) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count <= count + CNT_W'(inflight) - CNT_W'(pop);
        end
    end

    // FIFO storage needs no reset since the head is only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (reset && !redirect_valid && inflight) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule
